// File: rtl/fm_demodulate.sv
// fm_demodulate: FM discriminator stage of the radio chain.
// Each complex input sample is multiplied by the conjugate of the previous
// sample. A quantized arctangent of that product gives the phase step,
// which is scaled by the demod gain and written to the downstream FIFO as
// one signed word.
// Optional build macro: FM_DEMOD_RADIX4_EN. When it is defined, the
// iterative divider retires two quotient bits per cycle instead of one.
// Results are bit-identical in both builds; only the latency changes.

module fm_demodulate #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int GAIN       = 758,
    parameter int QUAD1      = 804,
    parameter int QUAD3      = 2412
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] real_in,
    input  logic                  real_empty,
    output logic                  real_rd_en,
    input  logic [DATA_WIDTH-1:0] imag_in,
    input  logic                  imag_empty,
    output logic                  imag_rd_en,
    output logic [DATA_WIDTH-1:0] demod_out,
    output logic                  demod_wr_en,
    input  logic                  demod_full
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

`ifdef FM_DEMOD_RADIX4_EN
    localparam int DIV_CYCLES = W / 2;
`else
    localparam int DIV_CYCLES = W;
`endif

    localparam int CNTW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV_CYCLES - 1);

    localparam logic signed [W-1:0]  ONE_W     = W'(1);
    localparam logic signed [W-1:0]  GAIN_W    = W'(GAIN);
    localparam logic signed [W-1:0]  QUAD1_W   = W'(QUAD1);
    localparam logic signed [W-1:0]  QUAD3_W   = W'(QUAD3);
    localparam logic signed [PW-1:0] ROUND_FIX = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

    typedef enum logic [2:0] {
        S_READ,
        S_MULT,
        S_DIV_SETUP,
        S_DIV,
        S_ANGLE,
        S_GAIN,
        S_WRITE
    } state_t;

    // Full-width signed product, so nothing overflows before the rescale.
    function automatic logic signed [PW-1:0] mulWide(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        logic signed [PW-1:0] aWide;
        logic signed [PW-1:0] bWide;
        aWide = PW'(a);
        bWide = PW'(b);
        return aWide * bWide;
    endfunction

    // Divide by 2^BITS rounding toward zero, the way C integer division does.
    // A negative value is biased by 2^BITS-1 before the arithmetic shift.
    function automatic logic signed [W-1:0] dequant(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] biased;
        biased = x[PW-1] ? (x + ROUND_FIX) : x;
        return W'(biased >>> BITS);
    endfunction

    // Unsigned magnitude. The most negative input maps to 2^(W-1) without overflow.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    // One restoring-division step. The dividend shifts out of the top of quo,
    // and quotient bits shift in at the bottom. Returns {remainder, quo}.
    function automatic logic [PW-1:0] divStep(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] den);
        logic [W:0] trial;
        logic [W:0] diff;
        trial = {rem, quo[W-1]};
        diff  = trial - {1'b0, den};
        if (diff[W]) begin
            return {trial[W-1:0], quo[W-2:0], 1'b0};
        end
        return {diff[W-1:0], quo[W-2:0], 1'b1};
    endfunction

    state_t                state_q, state_d;
    logic signed [W-1:0]   curReal_q, curReal_d;
    logic signed [W-1:0]   curImag_q, curImag_d;
    logic signed [W-1:0]   prevReal_q, prevReal_d;
    logic signed [W-1:0]   prevImag_q, prevImag_d;
    logic signed [W-1:0]   prodReal_q, prodReal_d;
    logic signed [W-1:0]   prodImag_q, prodImag_d;
    logic signed [W-1:0]   base_q, base_d;
    logic                  quoNeg_q, quoNeg_d;
    logic [W-1:0]          rem_q, rem_d;
    logic [W-1:0]          quo_q, quo_d;
    logic [W-1:0]          den_q, den_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0]   angle_q, angle_d;
    logic signed [W-1:0]   demodOut_q, demodOut_d;

    logic signed [W-1:0]   absY;
    logic signed [W-1:0]   numer;
    logic signed [W-1:0]   denom;
    logic signed [W-1:0]   qSigned;
    logic signed [W-1:0]   angleTmp;
    logic [PW-1:0]         stepOne;
`ifdef FM_DEMOD_RADIX4_EN
    logic [PW-1:0]         stepTwo;
`endif
    logic                  fifoPop;

    // Both upstream FIFOs are popped together, and only when both hold a
    // sample, so the real and imag streams can never slip. The pop is held
    // off while reset is asserted.
    assign fifoPop     = (state_q == S_READ) && !real_empty && !imag_empty && !reset;
    assign real_rd_en  = fifoPop;
    assign imag_rd_en  = fifoPop;

    // The write strobe comes straight from the state and the full flag.
    // A full FIFO therefore stalls S_WRITE in the same cycle, and the
    // registered result stays on demod_out until the FIFO accepts it.
    assign demod_wr_en = (state_q == S_WRITE) && !demod_full;
    assign demod_out   = demodOut_q;

    // Next-state and datapath computation for every FSM step.
    always_comb begin
        state_d    = state_q;
        curReal_d  = curReal_q;
        curImag_d  = curImag_q;
        prevReal_d = prevReal_q;
        prevImag_d = prevImag_q;
        prodReal_d = prodReal_q;
        prodImag_d = prodImag_q;
        base_d     = base_q;
        quoNeg_d   = quoNeg_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        den_d      = den_q;
        cnt_d      = cnt_q;
        angle_d    = angle_q;
        demodOut_d = demodOut_q;
        absY       = '0;
        numer      = '0;
        denom      = '0;
        qSigned    = '0;
        angleTmp   = '0;
        stepOne    = '0;
`ifdef FM_DEMOD_RADIX4_EN
        stepTwo    = '0;
`endif

        case (state_q)
            S_READ: begin
                if (fifoPop) begin
                    curReal_d = real_in;
                    curImag_d = imag_in;
                    state_d   = S_MULT;
                end
            end

            S_MULT: begin
                // Conjugate product: cur * conj(prev), with each term rescaled separately.
                prodReal_d = dequant(mulWide(prevReal_q, curReal_q))
                           - dequant(-mulWide(prevImag_q, curImag_q));
                prodImag_d = dequant(mulWide(prevReal_q, curImag_q))
                           + dequant(-mulWide(prevImag_q, curReal_q));
                prevReal_d = curReal_q;
                prevImag_d = curImag_q;
                state_d    = S_DIV_SETUP;
            end

            S_DIV_SETUP: begin
                // The +1 on |y| keeps the denominator at one or more.
                absY = magnitude(prodImag_q) + ONE_W;
                if (!prodReal_q[W-1]) begin
                    numer  = (prodReal_q - absY) <<< BITS;
                    denom  = prodReal_q + absY;
                    base_d = QUAD1_W;
                end else begin
                    numer  = (prodReal_q + absY) <<< BITS;
                    denom  = absY - prodReal_q;
                    base_d = QUAD3_W;
                end
                quoNeg_d = numer[W-1] ^ denom[W-1];
                quo_d    = magnitude(numer);
                den_d    = magnitude(denom);
                rem_d    = '0;
                cnt_d    = CNT_LAST;
                state_d  = S_DIV;
            end

            S_DIV: begin
`ifdef FM_DEMOD_RADIX4_EN
                stepOne        = divStep(rem_q, quo_q, den_q);
                stepTwo        = divStep(stepOne[PW-1:W], stepOne[W-1:0], den_q);
                {rem_d, quo_d} = stepTwo;
`else
                stepOne        = divStep(rem_q, quo_q, den_q);
                {rem_d, quo_d} = stepOne;
`endif
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_ANGLE;
                end
            end

            S_ANGLE: begin
                // Re-apply the sign to the magnitude quotient. This truncates toward zero.
                qSigned  = quoNeg_q ? -$signed(quo_q) : $signed(quo_q);
                angleTmp = base_q - dequant(mulWide(QUAD1_W, qSigned));
                angle_d  = prodImag_q[W-1] ? -angleTmp : angleTmp;
                state_d  = S_GAIN;
            end

            S_GAIN: begin
                demodOut_d = dequant(mulWide(GAIN_W, angle_q));
                state_d    = S_WRITE;
            end

            S_WRITE: begin
                if (!demod_full) begin
                    state_d = S_READ;
                end
            end

            default: begin
                state_d = S_READ;
            end
        endcase
    end

    // State and datapath registers. Reset clears the sample history, so the
    // first sample after reset is demodulated against (0,0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_READ;
            curReal_q  <= '0;
            curImag_q  <= '0;
            prevReal_q <= '0;
            prevImag_q <= '0;
            prodReal_q <= '0;
            prodImag_q <= '0;
            base_q     <= '0;
            quoNeg_q   <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            cnt_q      <= '0;
            angle_q    <= '0;
            demodOut_q <= '0;
        end else begin
            state_q    <= state_d;
            curReal_q  <= curReal_d;
            curImag_q  <= curImag_d;
            prevReal_q <= prevReal_d;
            prevImag_q <= prevImag_d;
            prodReal_q <= prodReal_d;
            prodImag_q <= prodImag_d;
            base_q     <= base_d;
            quoNeg_q   <= quoNeg_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            den_q      <= den_d;
            cnt_q      <= cnt_d;
            angle_q    <= angle_d;
            demodOut_q <= demodOut_d;
        end
    end

endmodule
